// File: rtl/rv32_ctrl_pkg.sv
// RV32I multi-cycle control: shared opcodes, states,
// ALU operation codes and select bundle.
package rv32_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  // LT/LTU reuse the SLT/SLTU codes: the ALU result is the
  // same less-than bit, which keeps all ops in 4 bits.
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;
  localparam logic [3:0] ALU_EQ    = 4'd11;
  localparam logic [3:0] ALU_NE    = 4'd12;
  localparam logic [3:0] ALU_LT    = ALU_SLT;
  localparam logic [3:0] ALU_GE    = 4'd13;
  localparam logic [3:0] ALU_LTU   = ALU_SLTU;
  localparam logic [3:0] ALU_GEU   = 4'd14;

  localparam logic [1:0] ALUB_FOUR = 2'b00;
  localparam logic [1:0] ALUB_IMM  = 2'b01;
  localparam logic [1:0] ALUB_RS2  = 2'b10;

  typedef enum logic [3:0] {
    CL_OP,
    CL_OP_IMM,
    CL_LUI,
    CL_AUIPC,
    CL_JAL,
    CL_JALR,
    CL_BRANCH,
    CL_LOAD,
    CL_STORE,
    CL_NOP,
    CL_ILLEGAL
  } iclass_t;

  typedef struct packed {
    logic       alu_a_rs1;
    logic [1:0] alu_b;
    logic       mem_to_reg;
    logic       writes_rd;
    logic       pc_imm;
    logic       pc_base_pc;
  } sel_t;

  function automatic logic [3:0] arith_op(
    input logic [2:0] f3,
    input logic       alt,
    input logic       sub_ok
  );
    logic [3:0] op;
    op = ALU_ADD;
    unique case (f3)
      3'b000: op = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic [3:0] branch_op(
    input logic [2:0] f3
  );
    logic [3:0] op;
    op = ALU_EQ;
    case (f3)
      3'b001: op = ALU_NE;
      3'b100: op = ALU_LT;
      3'b101: op = ALU_GE;
      3'b110: op = ALU_LTU;
      3'b111: op = ALU_GEU;
      default: op = ALU_EQ;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32_ctrl_decode.sv
// Combinational instruction decode: class, ALU op and
// datapath selects derived from the registered IR.
module rv32_ctrl_decode
  import rv32_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output iclass_t     iclass,
  output logic [3:0]  alu_op,
  output sel_t        sel,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic       unused_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign alt    = instr[30];
  assign unused_bits = ^{instr[31], instr[29:15],
                         instr[11:7]};

  // Opcode to instruction class.
  always_comb begin
    iclass = CL_ILLEGAL;
    unique case (1'b1)
      (opcode == OPC_OP):     iclass = CL_OP;
      (opcode == OPC_OP_IMM): iclass = CL_OP_IMM;
      (opcode == OPC_LUI):    iclass = CL_LUI;
      (opcode == OPC_AUIPC):  iclass = CL_AUIPC;
      (opcode == OPC_JAL):    iclass = CL_JAL;
      (opcode == OPC_JALR):   iclass = CL_JALR;
      (opcode == OPC_BRANCH): iclass = CL_BRANCH;
      (opcode == OPC_LOAD):   iclass = CL_LOAD;
      (opcode == OPC_STORE):  iclass = CL_STORE;
      (opcode == OPC_FENCE):  iclass = CL_NOP;
      (opcode == OPC_SYSTEM): iclass = CL_NOP;
      default:                iclass = CL_ILLEGAL;
    endcase
  end

  // Per-class selects; unlisted classes keep the PC+4 NOP set.
  always_comb begin
    sel.alu_a_rs1  = 1'b1;
    sel.alu_b      = ALUB_FOUR;
    sel.mem_to_reg = 1'b1;
    sel.writes_rd  = 1'b0;
    sel.pc_imm     = 1'b0;
    sel.pc_base_pc = 1'b1;
    alu_op         = ALU_ADD;
    case (iclass)
      CL_OP: begin
        sel.alu_b     = ALUB_RS2;
        sel.writes_rd = 1'b1;
        alu_op        = arith_op(funct3, alt, 1'b1);
      end
      CL_OP_IMM: begin
        sel.alu_b     = ALUB_IMM;
        sel.writes_rd = 1'b1;
        alu_op        = arith_op(funct3, alt, 1'b0);
      end
      CL_LUI: begin
        sel.alu_b     = ALUB_IMM;
        sel.writes_rd = 1'b1;
        alu_op        = ALU_PASSB;
      end
      CL_AUIPC: begin
        sel.alu_a_rs1 = 1'b0;
        sel.alu_b     = ALUB_IMM;
        sel.writes_rd = 1'b1;
      end
      CL_JAL: begin
        sel.alu_a_rs1 = 1'b0;
        sel.writes_rd = 1'b1;
        sel.pc_imm    = 1'b1;
      end
      CL_JALR: begin
        sel.alu_a_rs1  = 1'b0;
        sel.writes_rd  = 1'b1;
        sel.pc_imm     = 1'b1;
        sel.pc_base_pc = 1'b0;
      end
      CL_BRANCH: begin
        sel.alu_b = ALUB_RS2;
        alu_op    = branch_op(funct3);
      end
      CL_LOAD: begin
        sel.alu_b      = ALUB_IMM;
        sel.mem_to_reg = 1'b0;
        sel.writes_rd  = 1'b1;
      end
      CL_STORE: begin
        sel.alu_b = ALUB_IMM;
      end
      default: ;
    endcase
  end

  assign illegal = (iclass == CL_ILLEGAL);

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// RV32I multi-cycle control FSM: IR, branch flag, instret
// and all datapath selects / strobes.
module rv32_multicycle_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter int INSTRET_W       = 32
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          imem_rdata,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 branch_taken,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 ir_we,
  output logic                 reg_we,
  output logic                 pc_we,
  output logic                 PCASRC,
  output logic                 PCBSRC,
  output logic                 ALUAsrc,
  output logic [1:0]           ALUBsrc,
  output logic                 MemtoReg,
  output logic [3:0]           alu_op,
  output logic [31:0]          instr,
  output logic [INSTRET_W-1:0] instret,
  output logic                 halted
);

  state_t     state;
  logic       br_flag;
  iclass_t    iclass;
  logic [3:0] dec_alu_op;
  sel_t       sel;
  logic       illegal;
  logic       is_mem;
  logic       is_store;
  logic       is_branch;
  logic       rd_nz;
  logic       sel_live;

  rv32_ctrl_decode u_decode (
    .instr   (instr),
    .iclass  (iclass),
    .alu_op  (dec_alu_op),
    .sel     (sel),
    .illegal (illegal)
  );

  assign is_store  = (iclass == CL_STORE);
  assign is_mem    = (iclass == CL_LOAD) || is_store;
  assign is_branch = (iclass == CL_BRANCH);
  assign rd_nz     = |instr[11:7];
  assign sel_live  = (state == EXEC) || (state == MEM) ||
                     (state == WB);

  // Sequencer, IR load, branch flag and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      instr   <= '0;
      instret <= '0;
      br_flag <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ready) begin
            instr <= imem_rdata;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (illegal)
            state <= HALT_ON_ILLEGAL ? HALT : WB;
          else
            state <= EXEC;
        end
        EXEC: begin
          br_flag <= branch_taken;
          state   <= is_mem ? MEM : WB;
        end
        MEM: begin
          if (dmem_ready)
            state <= WB;
        end
        WB: begin
          instret <= instret + INSTRET_W'(1);
          state   <= FETCH;
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Outputs from state and IR; reset forces the idle set so
  // an in-flight request drops immediately.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    reg_we   = 1'b0;
    pc_we    = 1'b0;
    halted   = 1'b0;
    PCASRC   = 1'b0;
    PCBSRC   = 1'b1;
    ALUAsrc  = 1'b1;
    ALUBsrc  = ALUB_FOUR;
    MemtoReg = 1'b1;
    alu_op   = ALU_ADD;
    if (!rst && sel_live) begin
      ALUAsrc  = sel.alu_a_rs1;
      ALUBsrc  = sel.alu_b;
      alu_op   = dec_alu_op;
      MemtoReg = sel.mem_to_reg;
      PCBSRC   = sel.pc_base_pc;
      PCASRC   = is_branch ? ((state == WB) && br_flag)
                           : sel.pc_imm;
    end
    if (!rst) begin
      case (state)
        FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
        end
        WB: begin
          pc_we  = 1'b1;
          reg_we = sel.writes_rd && rd_nz;
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rv32_multicycle_ctrl.md
Name: rv32_multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback, and drives all datapath mux selects: PC adder operands, ALU operands and the writeback source. It also drives the register, IR and PC write strobes, plus the instruction- and data-memory request handshakes. It holds the registered instruction word and a retired-instruction counter.

Parameters:
HALT_ON_ILLEGAL, 1, 1 = an illegal opcode enters HALT; 0 = it retires as a NOP (PC+4).
INSTRET_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
imem_rdata  in  32  instruction from instruction memory
imem_ready  in  1  instruction-fetch completion
dmem_ready  in  1  data-access completion
branch_taken  in  1  comparator result for the current branch (valid in EXEC)
imem_req  out  1  fetch request
dmem_req  out  1  data-access request
dmem_we  out  1  store enable (qualifies dmem_req)
ir_we  out  1  IR load strobe
reg_we  out  1  register-file write
pc_we  out  1  PC load strobe
PCASRC  out  1  PC adder operand B: 1 = imm, 0 = constant 4
PCBSRC  out  1  PC adder operand A: 1 = PC, 0 = rs1
ALUAsrc  out  1  ALU operand A: 1 = rs1, 0 = PC
ALUBsrc  out  2  ALU operand B: 00 = 4, 01 = imm, 10 = rs2; 11 is never driven
MemtoReg  out  1  writeback source: 1 = ALU result, 0 = load data
alu_op  out  4  ALU operation code (package constants)
instr  out  32  registered instruction word
instret  out  INSTRET_W  count of retired instructions
halted  out  1  FSM in HALT

Behaviour:
- Reset (sync, high): state = FETCH, instr = 0, instret = 0.
  - All strobes and requests are 0, halted = 0.
  - Selects take defaults: PCASRC = 0, PCBSRC = 1, ALUAsrc = 1, ALUBsrc = 00, MemtoReg = 1, alu_op = ADD.
- Reset mid-access abandons the access with no write. The memories must tolerate a request dropping.
- Outputs are combinational from state and the registered instr. There is no decode path from imem_rdata to the outputs.
- FETCH: imem_req = 1 until imem_ready.
  - On the imem_ready cycle: ir_we = 1, instr <= imem_rdata, next = DECODE.
  - Otherwise stay in FETCH.
- DECODE: 1 cycle for register-file read. Illegal opcode goes to HALT (HALT_ON_ILLEGAL = 1) or WB as a NOP; otherwise next = EXEC.
- EXEC: 1 cycle. Loads and stores go to MEM; everything else goes to WB.
- MEM: dmem_req = 1 (dmem_we = 1 for stores) held until dmem_ready.
  - Address comes from the ALU (ALUAsrc = 1, ALUBsrc = 01, ADD), with selects held stable through MEM.
  - On dmem_ready, next = WB.
- WB: 1 cycle. pc_we = 1 and instret += 1, wrapping modulo 2^INSTRET_W.
  - reg_we = 1 only if the class writes rd and rd != 0.
  - Next = FETCH.
- HALT: absorbing until rst. halted = 1, all strobes 0, instret frozen.
- Per-class selects, held from EXEC through WB:
  - OP: A = rs1, B = 10, alu_op from funct3/funct7[5], MemtoReg = 1.
  - OP-IMM: B = 01; funct7[5] is used only for SRAI.
  - LUI: B = 01, alu_op = PASSB.
  - AUIPC: A = PC, B = 01, ADD.
  - JAL: A = PC, B = 00, ADD (rd = PC+4); PCBSRC = 1, PCASRC = 1.
  - JALR: same rd path; PCBSRC = 0, PCASRC = 1 (the datapath clears bit 0).
  - BRANCH: A = rs1, B = 10, alu_op = compare per funct3, reg_we = 0. branch_taken is sampled in EXEC into a flag; in WB, PCBSRC = 1 and PCASRC = flag.
  - LOAD: MemtoReg = 0 in WB.
  - STORE: reg_we = 0.
  - FENCE/SYSTEM: NOP, PC+4.
  - All non-jump, non-taken classes: PCBSRC = 1, PCASRC = 0.
- Latency, excluding memory wait states: ALU/branch/jump = 4 cycles, load/store = 5 cycles.
- imem_ready or dmem_ready asserted outside its own state is ignored.

Decomposition:
- Package rv32_ctrl_pkg holds:
  - opcode constants
  - state enum (FETCH, DECODE, EXEC, MEM, WB, HALT)
  - alu_op codes (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB, EQ, NE, LT, GE, LTU, GEU)
  - ALUBsrc encodings
- One combinational sub-module, rv32_ctrl_decode: instr in, class, alu_op, select bundle and illegal flag out.
- The FSM, IR, branch flag and instret counter stay in the top level.

Test Plan:
- ADDI 0x00500093, imem_ready on first request -> ir_we in cycle 1; EXEC shows ALUAsrc=1, ALUBsrc=01, ADD; WB shows reg_we=1, MemtoReg=1, pc_we=1 with PCASRC=0, PCBSRC=1; instret = 1; back in FETCH on cycle 5.
- LW 0x0000A103, dmem_ready delayed 3 cycles -> dmem_req held 4 cycles with dmem_we=0; WB has MemtoReg=0, reg_we=1; total 8 cycles.
- SW 0x0020A223 -> dmem_req=1, dmem_we=1 in MEM; WB has reg_we=0, pc_we=1.
- BEQ 0x00000463 with branch_taken=1, then repeated with 0 -> WB PCASRC = 1 / 0, PCBSRC = 1, reg_we = 0.
- JAL 0x010000EF -> ALUAsrc=0, ALUBsrc=00, reg_we=1; PCASRC=1, PCBSRC=1.
- Illegal 0x00000000 -> HALT_ON_ILLEGAL=1: halted=1, no strobes for 20 cycles, instret unchanged. rst in any state (including mid-MEM) -> next cycle FETCH, instret = 0.
